// File: rtl/change_dispenser.sv
// Coin payout unit: accepts a change amount and ejects coins greedily (dollar, quarter,
// dime, nickel), one timed solenoid pulse plus recovery gap per coin, then pulses done.
module change_dispenser #(
  parameter int unsigned PULSE_CYCLES = 4,
  parameter int unsigned GAP_CYCLES   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        change_valid,
  input  logic [15:0] change,
  output logic        ready,
  output logic        eject_dollar,
  output logic        eject_quarter,
  output logic        eject_dime,
  output logic        eject_nickel,
  output logic [15:0] remaining,
  output logic [7:0]  coin_count,
  output logic        residue_err,
  output logic        done
);

  localparam logic [7:0] PulseLast = 8'(PULSE_CYCLES - 1);
  localparam logic [7:0] GapLast   = 8'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [2:0] {StIdle, StSelect, StPulse, StGap, StDone} state_e;

  state_e      state_q, state_d;
  logic [1:0]  sel_q, sel_d;  // 0 dollar, 1 quarter, 2 dime, 3 nickel
  logic [7:0]  cnt_q, cnt_d;
  logic [15:0] remaining_q, remaining_d;
  logic [7:0]  coin_q, coin_d;
  logic        residue_q, residue_d;
  logic        ready_q, ready_d;
  logic        done_q, done_d;
  logic [3:0]  eject_q, eject_d;
  logic [15:0] denom;

  always_comb begin
    unique case (sel_q)
      2'd0:    denom = 16'd100;
      2'd1:    denom = 16'd25;
      2'd2:    denom = 16'd10;
      default: denom = 16'd5;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    cnt_d       = cnt_q;
    remaining_d = remaining_q;
    coin_d      = coin_q;
    residue_d   = residue_q;

    unique case (state_q)
      StIdle: begin
        if (change_valid) begin
          remaining_d = change;
          coin_d      = 8'd0;
          residue_d   = (change % 16'd5) != 16'd0;
          state_d     = StSelect;
        end
      end
      StSelect: begin
        if (remaining_q < 16'd5) begin
          state_d = StDone;
        end else begin
          if (remaining_q >= 16'd100)     sel_d = 2'd0;
          else if (remaining_q >= 16'd25) sel_d = 2'd1;
          else if (remaining_q >= 16'd10) sel_d = 2'd2;
          else                            sel_d = 2'd3;
          cnt_d   = PulseLast;
          state_d = StPulse;
        end
      end
      StPulse: begin
        if (cnt_q == 8'd0) begin
          // The coin only counts once its full pulse has completed.
          remaining_d = remaining_q - denom;
          coin_d      = (coin_q == 8'hFF) ? coin_q : coin_q + 8'd1;
          cnt_d       = GapLast;
          state_d     = (GAP_CYCLES == 0) ? StSelect : StGap;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      StGap: begin
        if (cnt_q == 8'd0) state_d = StSelect;
        else               cnt_d   = cnt_q - 8'd1;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Outputs are registered from the next state so they line up with the state register.
    ready_d = (state_d == StIdle);
    done_d  = (state_d == StDone);
    eject_d = (state_d == StPulse) ? (4'b1000 >> sel_d) : 4'b0000;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      sel_q       <= 2'd0;
      cnt_q       <= 8'd0;
      remaining_q <= 16'd0;
      coin_q      <= 8'd0;
      residue_q   <= 1'b0;
      ready_q     <= 1'b1;
      done_q      <= 1'b0;
      eject_q     <= 4'b0000;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      cnt_q       <= cnt_d;
      remaining_q <= remaining_d;
      coin_q      <= coin_d;
      residue_q   <= residue_d;
      ready_q     <= ready_d;
      done_q      <= done_d;
      eject_q     <= eject_d;
    end
  end

  assign ready         = ready_q;
  assign done          = done_q;
  assign remaining     = remaining_q;
  assign coin_count    = coin_q;
  assign residue_err   = residue_q;
  assign eject_dollar  = eject_q[3];
  assign eject_quarter = eject_q[2];
  assign eject_dime    = eject_q[1];
  assign eject_nickel  = eject_q[0];

endmodule
